// File: rtl/dsp_pkg.sv
// Shared types and sizing helpers for the DDS-multiply-FIR stream chain.
package dsp_pkg;

    localparam int DATA_W_DEF = 8;

    typedef logic signed [DATA_W_DEF-1:0] sample_t;

    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_FULL  = 1'b1
    } hold_state_e;

    // Sum of 2^decim_log2 samples can never exceed this width.
    function automatic int acc_width(input int data_w, input int decim_log2);
        return data_w + decim_log2;
    endfunction

endpackage

// File: rtl/out_hold_reg.sv
// Single-entry valid/ready output register with sticky overrun detection.
module out_hold_reg
    import dsp_pkg::*;
#(
    parameter int W = DATA_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         out_ready,
    input  logic         clr_ovr,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    output logic         ovr
);

    hold_state_e  state_q, state_d;
    logic [W-1:0] data_q, data_d;
    logic         ovr_q, ovr_d;
    logic         full;
    logic         overrun;

    assign full    = (state_q == HOLD_FULL);
    assign overrun = full && !out_ready && load;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load && (!full || out_ready)) begin
            state_d = HOLD_FULL;
            data_d  = load_data;
        end else if (full && out_ready) begin
            state_d = HOLD_EMPTY;
        end
        // A new overrun wins over a same-cycle clear.
        ovr_d = overrun || (ovr_q && !clr_ovr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= HOLD_EMPTY;
            data_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ovr_q   <= ovr_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = full;
    assign ovr       = ovr_q;

endmodule

// File: rtl/fir_decimator.sv
// Accumulate-and-dump decimator: averages 2^DECIM_LOG2 samples per output.
module fir_decimator
    import dsp_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DECIM_LOG2 = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] in_sample,
    input  logic                     in_valid,
    output logic signed [DATA_W-1:0] out_sample,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic                     clr_ovr,
    output logic                     ovr,
    output logic [DECIM_LOG2-1:0]    frame_cnt
);

    localparam int AW = acc_width(DATA_W, DECIM_LOG2);

    logic signed [AW-1:0]     acc_q, acc_d;
    logic signed [AW-1:0]     sum;
    logic [DECIM_LOG2-1:0]    cnt_q, cnt_d;
    logic                     last;
    logic                     dump;
    logic [DATA_W-1:0]        result;
    logic [DATA_W-1:0]        hold_data;

    assign sum  = acc_q + {{DECIM_LOG2{in_sample[DATA_W-1]}}, in_sample};
    assign last = &cnt_q;
    assign dump = in_valid && last;

    // Dropping the low bits is an arithmetic shift rounding toward -inf.
    assign result = sum[AW-1:DECIM_LOG2];

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (in_valid) begin
            if (last) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    out_hold_reg #(
        .W(DATA_W)
    ) u_hold (
        .clk      (clk),
        .rst      (rst),
        .load     (dump),
        .load_data(result),
        .out_ready(out_ready),
        .clr_ovr  (clr_ovr),
        .out_data (hold_data),
        .out_valid(out_valid),
        .ovr      (ovr)
    );

    assign out_sample = $signed(hold_data);
    assign frame_cnt  = cnt_q;

endmodule
